// File: rtl/uart_tx_encoder.sv
// Frame encoder for the UART return path: header, response code, data bytes MSB
// first and an XOR checksum, handed byte by byte to the UART TX core.
module uart_tx_encoder #(
  parameter int unsigned UART_NUM_DATA = 8,
  parameter int unsigned CMDLENGTH     = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter logic [UART_NUM_DATA-1:0] HEADER = 8'h5A
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sys_locked,
  input  logic [CMDLENGTH-1:0]     frame_code,
  input  logic [DATA_WIDTH-1:0]    frame_data,
  input  logic                     frame_vld,
  output logic                     frame_rdy,
  output logic [UART_NUM_DATA-1:0] uart_wdata,
  output logic                     uart_tx_vld,
  input  logic                     uart_tx_rdy,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned NB    = DATA_WIDTH / UART_NUM_DATA;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CODE,
    S_DATA,
    S_CSUM
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [UART_NUM_DATA-1:0] csum_q, csum_d;
  logic [CMDLENGTH-1:0]     code_q, code_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     done_q, done_d;

  logic                     abort;
  logic                     byte_acc;
  logic [UART_NUM_DATA-1:0] cur_byte;

  // Unlock behaves exactly like reset so a partial frame is never resumed.
  assign abort = rst | ~sys_locked;

  // Outputs decode registered state only; frame_rdy is the sole exception.
  assign frame_rdy   = (state_q == S_IDLE) & sys_locked & ~rst;
  assign busy        = (state_q != S_IDLE);
  assign uart_tx_vld = (state_q != S_IDLE);
  assign uart_wdata  = cur_byte;
  assign frame_done  = done_q;
  assign byte_acc    = uart_tx_vld & uart_tx_rdy;

  // Data register shifts left per accepted byte, so the top byte is always current.
  always_comb begin
    cur_byte = '0;
    case (state_q)
      S_HDR:   cur_byte = HEADER;
      S_CODE:  cur_byte = UART_NUM_DATA'(code_q);
      S_DATA:  cur_byte = data_q[DATA_WIDTH-1 -: UART_NUM_DATA];
      S_CSUM:  cur_byte = csum_q;
      default: cur_byte = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    code_d  = code_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_vld && frame_rdy) begin
          code_d  = frame_code;
          data_d  = frame_data;
          csum_d  = '0;
          idx_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (byte_acc) state_d = S_CODE;
      end
      S_CODE: begin
        if (byte_acc) begin
          csum_d  = csum_q ^ cur_byte;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (byte_acc) begin
          csum_d = csum_q ^ cur_byte;
          data_d = data_q << UART_NUM_DATA;
          if (idx_q == IDX_W'(NB - 1)) begin
            state_d = S_CSUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_CSUM: begin
        if (byte_acc) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      code_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      code_q  <= code_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_encoder.sv
// Directed bench for uart_tx_encoder: expected frame bytes are queued when a
// frame is offered and popped as the encoder hands each byte to the UART.
module tb_uart_tx_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_locked;
  logic [3:0]  frame_code;
  logic [15:0] frame_data;
  logic        frame_vld;
  logic        frame_rdy;
  logic [7:0]  uart_wdata;
  logic        uart_tx_vld;
  logic        uart_tx_rdy;
  logic        busy;
  logic        frame_done;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  uart_tx_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .sys_locked  (sys_locked),
    .frame_code  (frame_code),
    .frame_data  (frame_data),
    .frame_vld   (frame_vld),
    .frame_rdy   (frame_rdy),
    .uart_wdata  (uart_wdata),
    .uart_tx_vld (uart_tx_vld),
    .uart_tx_rdy (uart_tx_rdy),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference frame: header, code byte, data MSB first, XOR of code and data bytes.
  task automatic push_frame(input logic [3:0] code, input logic [15:0] data);
    logic [7:0] cb, d1, d0;
    cb = {4'h0, code};
    d1 = data[15:8];
    d0 = data[7:0];
    exp_q.push_back(8'h5A);
    exp_q.push_back(cb);
    exp_q.push_back(d1);
    exp_q.push_back(d0);
    exp_q.push_back(cb ^ d1 ^ d0);
  endtask

  // Drain the queued frame, stalling the UART 'stall' cycles before each accept.
  // Returns positioned on the frame_done cycle.
  task automatic drain(input string tag, input int stall);
    int         scnt;
    logic [7:0] held;
    scnt = 0;
    held = '0;
    for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
      chk({tag, "_vld"}, 16'(uart_tx_vld), 16'd1);
      chk({tag, "_done_low"}, 16'(frame_done), 16'd0);
      if (scnt < stall) begin
        uart_tx_rdy = 1'b0;
        if (scnt == 0) held = uart_wdata;
        else chk({tag, "_stable"}, 16'(uart_wdata), 16'(held));
        scnt++;
      end else begin
        uart_tx_rdy = 1'b1;
        chk({tag, "_byte"}, 16'(uart_wdata), 16'(exp_q.pop_front()));
        scnt = 0;
      end
      tick();
    end
    chk({tag, "_timeout_left"}, 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    uart_tx_rdy = 1'b0;
    chk({tag, "_done"}, 16'(frame_done), 16'd1);
    chk({tag, "_busy_end"}, 16'(busy), 16'd0);
    chk({tag, "_rdy_end"}, 16'(frame_rdy), 16'd1);
  endtask

  initial begin
    rst         = 1'b1;
    sys_locked  = 1'b1;
    frame_code  = '0;
    frame_data  = '0;
    frame_vld   = 1'b0;
    uart_tx_rdy = 1'b0;

    // 1: reset
    tick();
    tick();
    chk("rst_vld", 16'(uart_tx_vld), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(frame_done), 16'd0);
    chk("rst_rdy_in_rst", 16'(frame_rdy), 16'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy_after", 16'(frame_rdy), 16'd1);

    // 2: full-rate frame
    frame_code = 4'h2;
    frame_data = 16'h1234;
    frame_vld  = 1'b1;
    push_frame(4'h2, 16'h1234);
    tick();
    frame_vld = 1'b0;
    drain("t2", 0);
    tick();
    chk("t2_done_pulse", 16'(frame_done), 16'd0);

    // 3: same frame with 3 stall cycles before each accept
    frame_vld = 1'b1;
    push_frame(4'h2, 16'h1234);
    tick();
    frame_vld = 1'b0;
    drain("t3", 3);
    tick();
    chk("t3_done_pulse", 16'(frame_done), 16'd0);

    // 4: new data offered while busy is ignored, taken after frame_done
    frame_code = 4'h3;
    frame_data = 16'hA5C3;
    frame_vld  = 1'b1;
    push_frame(4'h3, 16'hA5C3);
    tick();
    frame_code = 4'h4;
    frame_data = 16'hBEEF;
    drain("t4a", 1);
    push_frame(4'h4, 16'hBEEF);
    tick();
    frame_vld = 1'b0;
    chk("t4_second_busy", 16'(busy), 16'd1);
    drain("t4b", 0);
    tick();
    chk("t4_done_pulse", 16'(frame_done), 16'd0);

    // 5: unlock while the first data byte is stalled
    frame_code = 4'h2;
    frame_data = 16'h1234;
    frame_vld  = 1'b1;
    tick();
    frame_vld   = 1'b0;
    uart_tx_rdy = 1'b1;
    chk("t5_hdr", 16'(uart_wdata), 16'h5A);
    tick();
    chk("t5_code", 16'(uart_wdata), 16'h02);
    tick();
    uart_tx_rdy = 1'b0;
    chk("t5_d1", 16'(uart_wdata), 16'h12);
    tick();
    chk("t5_d1_stall", 16'(uart_wdata), 16'h12);
    sys_locked = 1'b0;
    #1;
    chk("t5_rdy_unlocked", 16'(frame_rdy), 16'd0);
    tick();
    chk("t5_abort_vld", 16'(uart_tx_vld), 16'd0);
    chk("t5_abort_busy", 16'(busy), 16'd0);
    chk("t5_abort_done", 16'(frame_done), 16'd0);
    uart_tx_rdy = 1'b1;
    tick();
    chk("t5_abort_done2", 16'(frame_done), 16'd0);
    chk("t5_abort_vld2", 16'(uart_tx_vld), 16'd0);
    uart_tx_rdy = 1'b0;
    sys_locked  = 1'b1;
    frame_code  = 4'hF;
    frame_data  = 16'hFFFF;
    frame_vld   = 1'b1;
    push_frame(4'hF, 16'hFFFF);
    tick();
    frame_vld = 1'b0;
    drain("t5b", 0);
    tick();
    chk("t5_done_pulse", 16'(frame_done), 16'd0);

    // 6: back-to-back frames with frame_vld held high
    frame_code = 4'h1;
    frame_data = 16'h0000;
    frame_vld  = 1'b1;
    push_frame(4'h1, 16'h0000);
    tick();
    drain("t6a", 0);
    chk("t6_gap_vld", 16'(uart_tx_vld), 16'd0);
    push_frame(4'h1, 16'h0000);
    tick();
    frame_vld = 1'b0;
    chk("t6_restart_busy", 16'(busy), 16'd1);
    drain("t6b", 0);
    tick();
    chk("t6_idle_busy", 16'(busy), 16'd0);
    chk("t6_idle_done", 16'(frame_done), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
